mac_seq_ctrl: RTL



---
 rtl/mac_seq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: streams a dot-product job of signed (data, weight) beats into a
// MAC lane, waits out the MAC pipeline and returns the accumulated result.
module mac_seq_ctrl #(
  parameter int unsigned IN_BIT     = 8,
  parameter int unsigned WEIGHT_BIT = 8,
  parameter int unsigned OUT_BIT    = 20,
  parameter int unsigned OP_BIT     = 2,
  parameter int unsigned LEN_BIT    = 10,
  parameter int unsigned MAC_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_BIT-1:0]    len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_BIT-1:0]     in_data,
  input  logic [WEIGHT_BIT-1:0] in_weight,
  output logic                  mac_ena,
  output logic [OP_BIT-1:0]     mac_op,
  output logic [IN_BIT-1:0]     mac_data,
  output logic [WEIGHT_BIT-1:0] mac_weight,
  input  logic [OUT_BIT-1:0]    mac_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_BIT-1:0]    res_data
);

  // Drain covers the MAC input register plus MAC_LAT result stages plus one
  // cycle so mac_result is sampled only once it is stable.
  localparam int unsigned DRAIN_CYC = MAC_LAT + 2;
  localparam int unsigned LAT_BIT   = $clog2(DRAIN_CYC + 1);

  localparam logic [OP_BIT-1:0]  OP_NOP     = OP_BIT'(0);
  localparam logic [OP_BIT-1:0]  OP_LOAD    = OP_BIT'(1);
  localparam logic [OP_BIT-1:0]  OP_ACC     = OP_BIT'(2);
  localparam logic [LAT_BIT-1:0] DRAIN_LOAD = LAT_BIT'(DRAIN_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               state;
  logic [LEN_BIT-1:0]   beat_cnt;
  logic [LAT_BIT-1:0]   drain_cnt;
  logic                 first;

  // State-decoded status and upstream ready.
  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_FEED);

  // Sequencer FSM with registered MAC and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      first      <= 1'b0;
      mac_ena    <= 1'b0;
      mac_op     <= OP_NOP;
      mac_data   <= '0;
      mac_weight <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
    end else begin
      // MAC is idle unless a beat was accepted this cycle.
      mac_ena <= 1'b0;
      mac_op  <= OP_NOP;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              beat_cnt <= len;
              first    <= 1'b1;
              state    <= S_FEED;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= S_OUT;
            end
          end
        end
        S_FEED: begin
          if (in_valid) begin
            mac_ena    <= 1'b1;
            mac_op     <= first ? OP_LOAD : OP_ACC;
            mac_data   <= in_data;
            mac_weight <= in_weight;
            first      <= 1'b0;
            beat_cnt   <= beat_cnt - LEN_BIT'(1);
            if (beat_cnt == LEN_BIT'(1)) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - LAT_BIT'(1);
          if (drain_cnt == LAT_BIT'(1)) begin
            res_data  <= mac_result;
            res_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
